// File: rtl/stream_mux_n_pkg.sv
// Shared definitions for the stream multiplexer: mode encodings and the
// channel-index width helper.
package mux_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // A single-channel index still needs one bit, so the width never drops to zero.
    function automatic int idx_width(input int n);
        if (n <= 2) begin
            return 1;
        end else begin
            return $clog2(n);
        end
    endfunction

endpackage

// File: rtl/stream_mux_n_if.sv
// Handshake bundle between N producers, the stream mux and one consumer.
// master = producer/consumer side, slave = the mux itself.
interface stream_mux_n_if
    import mux_pkg::*;
#(
    parameter int Mux_Width  = 8,
    parameter int Num_Inputs = 4,
    parameter int Sel_Width  = idx_width(Num_Inputs)
);
    logic [Num_Inputs*Mux_Width-1:0] In_Data;
    logic [Num_Inputs-1:0]           In_Valid;
    logic [Num_Inputs-1:0]           In_Ready;
    logic [Sel_Width-1:0]            Control;
    logic                            Mode;
    logic [Mux_Width-1:0]            Out_Data;
    logic                            Out_Valid;
    logic                            Out_Ready;
    logic [Sel_Width-1:0]            Out_Chan;

    modport master (
        output In_Data, In_Valid, Control, Mode, Out_Ready,
        input  In_Ready, Out_Data, Out_Valid, Out_Chan
    );

    modport slave (
        input  In_Data, In_Valid, Control, Mode, Out_Ready,
        output In_Ready, Out_Data, Out_Valid, Out_Chan
    );
endinterface

// File: rtl/stream_mux_n_rr_arbiter.sv
// Round-robin arbiter: grants the first requester after the last winner.
// The pointer resets to the top channel so channel 0 wins first.
module rr_arbiter
    import mux_pkg::*;
#(
    parameter int  Num_Inputs = 4,
    localparam int Sel_Width  = idx_width(Num_Inputs)
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic [Num_Inputs-1:0] req,
    input  logic                  adv,
    output logic [Num_Inputs-1:0] gnt,
    output logic [Sel_Width-1:0]  gnt_idx
);
    logic [Sel_Width-1:0]  ptr_r;
    logic [Sel_Width-1:0]  idx_s;
    logic [Sel_Width-1:0]  cidx_s;
    logic [Num_Inputs-1:0] gnt_s;
    logic                  found_s;
    int                    cand_s;

    // Search upward from ptr+1, wrapping past the last channel
    always_comb begin
        gnt_s   = '0;
        idx_s   = '0;
        found_s = 1'b0;
        cand_s  = 0;
        cidx_s  = '0;
        for (int k = 1; k <= Num_Inputs; k++) begin
            cand_s = int'(ptr_r) + k;
            if (cand_s >= Num_Inputs) begin
                cand_s = cand_s - Num_Inputs;
            end else begin
                cand_s = cand_s;
            end
            cidx_s = Sel_Width'(cand_s);
            if (!found_s && req[cidx_s]) begin
                found_s       = 1'b1;
                gnt_s[cidx_s] = 1'b1;
                idx_s         = cidx_s;
            end else begin
                found_s = found_s;
            end
        end
    end

    // Pointer follows the winner only when the grant is actually taken
    always_ff @(posedge Clk) begin
        if (Rst) begin
            ptr_r <= Sel_Width'(Num_Inputs - 1);
        end else if (adv) begin
            ptr_r <= idx_s;
        end else begin
            ptr_r <= ptr_r;
        end
    end

    assign gnt     = gnt_s;
    assign gnt_idx = idx_s;
endmodule

// File: rtl/stream_mux_n.sv
// N:1 stream multiplexer with a registered output stage and valid/ready handshakes.
// Round-robin mode is compiled in only when STREAM_MUX_RR_EN is defined.
module stream_mux_n
    import mux_pkg::*;
#(
    parameter int Mux_Width  = 8,
    parameter int Num_Inputs = 4,
    parameter int Sel_Width  = idx_width(Num_Inputs)
) (
    input logic           Clk,
    input logic           Rst,
    stream_mux_n_if.slave mif
);
    localparam logic [31:0] NUM_IN_U = 32'(Num_Inputs);

    logic                  load_en_s;
    logic                  fixed_ok_s;
    logic                  xfer_s;
    logic [Num_Inputs-1:0] fixed_oh_s;
    logic [Num_Inputs-1:0] gnt_oh_s;
    logic [Num_Inputs-1:0] rdy_s;
    logic [Sel_Width-1:0]  gnt_idx_s;
    logic [Mux_Width-1:0]  data_s;
    logic [Mux_Width-1:0]  out_data_r;
    logic [Sel_Width-1:0]  out_chan_r;
    logic                  out_valid_r;

    assign load_en_s  = !out_valid_r || mif.Out_Ready;
    assign fixed_ok_s = (32'(mif.Control) < NUM_IN_U);

    // Fixed-select decode; an out-of-range Control grants nobody
    always_comb begin
        fixed_oh_s = '0;
        for (int i = 0; i < Num_Inputs; i++) begin
            fixed_oh_s[i] = fixed_ok_s && (mif.Control == Sel_Width'(i));
        end
    end

`ifdef STREAM_MUX_RR_EN
    logic                  rr_mode_s;
    logic [Num_Inputs-1:0] rr_oh_s;
    logic [Sel_Width-1:0]  rr_idx_s;

    assign rr_mode_s = (mif.Mode == MODE_RR);

    rr_arbiter #(
        .Num_Inputs (Num_Inputs)
    ) u_rr_arbiter (
        .Clk     (Clk),
        .Rst     (Rst),
        .req     (mif.In_Valid),
        .adv     (xfer_s && rr_mode_s),
        .gnt     (rr_oh_s),
        .gnt_idx (rr_idx_s)
    );

    // Grant source chosen by Mode each cycle
    always_comb begin
        if (rr_mode_s) begin
            gnt_oh_s  = rr_oh_s;
            gnt_idx_s = rr_idx_s;
        end else begin
            gnt_oh_s  = fixed_oh_s;
            gnt_idx_s = mif.Control;
        end
    end
`else
    logic unused_mode_s;
    assign unused_mode_s = mif.Mode;

    // Fixed-select only build
    always_comb begin
        gnt_oh_s  = fixed_oh_s;
        gnt_idx_s = mif.Control;
    end
`endif

    // Ready goes to the granted channel only while the register can take a word
    always_comb begin
        if (Rst || !load_en_s) begin
            rdy_s = '0;
        end else begin
            rdy_s = gnt_oh_s;
        end
    end

    assign xfer_s = |(rdy_s & mif.In_Valid);

    // AND-OR data select keyed by the one-hot grant
    always_comb begin
        data_s = '0;
        for (int i = 0; i < Num_Inputs; i++) begin
            data_s = data_s | ({Mux_Width{gnt_oh_s[i]}} & mif.In_Data[i*Mux_Width +: Mux_Width]);
        end
    end

    // Output register: load wins over drain so back-to-back transfers stay FULL
    always_ff @(posedge Clk) begin
        if (Rst) begin
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_chan_r  <= '0;
        end else if (xfer_s) begin
            out_valid_r <= 1'b1;
            out_data_r  <= data_s;
            out_chan_r  <= gnt_idx_s;
        end else if (out_valid_r && mif.Out_Ready) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    assign mif.In_Ready  = rdy_s;
    assign mif.Out_Data  = out_data_r;
    assign mif.Out_Valid = out_valid_r;
    assign mif.Out_Chan  = out_chan_r;
endmodule

// File: tb/tb_stream_mux_n.sv
// Scoreboard bench for stream_mux_n: a 4-input and a 3-input instance share stimulus.
// Expected words are queued at transfer time and popped by per-instance monitors.
module tb_stream_mux_n;
    import mux_pkg::*;

    typedef struct packed {
        logic [7:0] d;
        logic [1:0] c;
    } item_t;

    logic clk;
    logic rst;
    int   vectors;
    int   errors;

    stream_mux_n_if #(.Mux_Width(8), .Num_Inputs(4)) mif4 ();
    stream_mux_n_if #(.Mux_Width(8), .Num_Inputs(3)) mif3 ();

    stream_mux_n #(.Mux_Width(8), .Num_Inputs(4)) dut4 (.Clk(clk), .Rst(rst), .mif(mif4));
    stream_mux_n #(.Mux_Width(8), .Num_Inputs(3)) dut3 (.Clk(clk), .Rst(rst), .mif(mif3));

    item_t q4[$];
    item_t q3[$];
    bit    m_full[2];
    int    m_ptr[2];
    bit    m_init;
    bit    post_rst;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Reference grant rule: fixed picks Control if in range; RR scans ptr+1.. modulo n.
    function automatic void pick(input int n, input int ptr, input logic [3:0] v, input int ctl,
                                 input bit rr, output bit has, output int g);
        has = 1'b0;
        g   = 0;
        if (rr) begin
            for (int k = 1; k <= n; k++) begin
                int c;
                c = (ptr + k) % n;
                if (!has && v[c]) begin
                    has = 1'b1;
                    g   = c;
                end
            end
        end else if (ctl < n) begin
            has = 1'b1;
            g   = ctl;
        end
    endfunction

    task automatic apply(input logic [3:0] v, input logic [31:0] d, input logic [1:0] ctl,
                         input logic md, input logic ordy, input logic r);
        int         n;
        int         g;
        bit         has;
        bit         rr;
        logic [3:0] vu;
        logic [3:0] exp_rdy;
        logic [3:0] act_rdy;
        logic       act_v;
        logic [7:0] act_d;
        logic [1:0] act_c;
        item_t      it;
        @(posedge clk);
        #1;
        rst           = r;
        mif4.In_Valid = v;
        mif4.In_Data  = d;
        mif4.Control  = ctl;
        mif4.Mode     = md;
        mif4.Out_Ready = ordy;
        mif3.In_Valid = v[2:0];
        mif3.In_Data  = d[23:0];
        mif3.Control  = ctl;
        mif3.Mode     = md;
        mif3.Out_Ready = ordy;
        @(negedge clk);
`ifdef STREAM_MUX_RR_EN
        rr = md;
`else
        rr = 1'b0;
`endif
        for (int u = 0; u < 2; u++) begin
            n  = (u == 0) ? 4 : 3;
            vu = (u == 0) ? v : (v & 4'h7);
            pick(n, m_ptr[u], vu, int'(ctl), rr, has, g);
            exp_rdy = (!r && has && (!m_full[u] || ordy)) ? (4'b0001 << g) : 4'b0000;
            if (u == 0) begin
                act_rdy = mif4.In_Ready; act_v = mif4.Out_Valid;
                act_d   = mif4.Out_Data; act_c = mif4.Out_Chan;
            end else begin
                act_rdy = {1'b0, mif3.In_Ready}; act_v = mif3.Out_Valid;
                act_d   = mif3.Out_Data;         act_c = mif3.Out_Chan;
            end
            check($sformatf("in_ready_n%0d", n), 32'(act_rdy), 32'(exp_rdy));
            if (m_init) check($sformatf("out_valid_n%0d", n), 32'(act_v), 32'(m_full[u]));
            if (post_rst) begin
                check($sformatf("rst_out_data_n%0d", n), 32'(act_d), 32'h0);
                check($sformatf("rst_out_chan_n%0d", n), 32'(act_c), 32'h0);
            end
            if (r) begin
                m_full[u] = 1'b0;
                m_ptr[u]  = n - 1;
                if (u == 0) q4.delete(); else q3.delete();
            end else if (exp_rdy != 4'b0000 && vu[g]) begin
                it.d = d[g*8 +: 8];
                it.c = 2'(g);
                if (u == 0) q4.push_back(it); else q3.push_back(it);
                m_full[u] = 1'b1;
                if (rr) m_ptr[u] = g;
            end else if (ordy) begin
                m_full[u] = 1'b0;
            end
        end
        if (r) m_init = 1'b1;
        post_rst = r;
    endtask

    // Monitor for the 4-input instance: compare held word every valid cycle, pop on accept
    always @(negedge clk) begin
        if (!rst && mif4.Out_Valid) begin
            if (q4.size() == 0) begin
                vectors++; errors++;
                $display("FAIL sb_n4: got valid word %0h, expected no word", mif4.Out_Data);
            end else begin
                check("out_data_n4", 32'(mif4.Out_Data), 32'(q4[0].d));
                check("out_chan_n4", 32'(mif4.Out_Chan), 32'(q4[0].c));
                if (mif4.Out_Ready) void'(q4.pop_front());
            end
        end
    end

    // Monitor for the 3-input instance
    always @(negedge clk) begin
        if (!rst && mif3.Out_Valid) begin
            if (q3.size() == 0) begin
                vectors++; errors++;
                $display("FAIL sb_n3: got valid word %0h, expected no word", mif3.Out_Data);
            end else begin
                check("out_data_n3", 32'(mif3.Out_Data), 32'(q3[0].d));
                check("out_chan_n3", 32'(mif3.Out_Chan), 32'(q3[0].c));
                if (mif3.Out_Ready) void'(q3.pop_front());
            end
        end
    end

    initial begin
        vectors = 0;
        errors  = 0;
        m_init  = 1'b0;
        post_rst = 1'b0;
        rst     = 1'b1;
        mif4.In_Valid = '0; mif4.In_Data = '0; mif4.Control = '0; mif4.Mode = 1'b0; mif4.Out_Ready = 1'b0;
        mif3.In_Valid = '0; mif3.In_Data = '0; mif3.Control = '0; mif3.Mode = 1'b0; mif3.Out_Ready = 1'b0;

        apply(4'h0, 32'h0, 2'd0, MODE_FIXED, 1'b0, 1'b1);
        apply(4'h0, 32'h0, 2'd0, MODE_FIXED, 1'b0, 1'b1);

        // fixed select of channel 2, then drain
        apply(4'hF, 32'h005A0000, 2'd2, MODE_FIXED, 1'b1, 1'b0);
        apply(4'h0, 32'h0,        2'd2, MODE_FIXED, 1'b1, 1'b0);

        // load 0x11, stall three cycles, then drain and reload together
        apply(4'hF, 32'h00110000, 2'd2, MODE_FIXED, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) apply(4'hF, 32'h00220000, 2'd2, MODE_FIXED, 1'b0, 1'b0);
        apply(4'hF, 32'h00330000, 2'd2, MODE_FIXED, 1'b1, 1'b0);
        apply(4'h0, 32'h0,        2'd2, MODE_FIXED, 1'b1, 1'b0);

        // out-of-range Control on the 3-input instance
        apply(4'h7, 32'h00CCBBAA, 2'd3, MODE_FIXED, 1'b1, 1'b0);
        apply(4'hF, 32'hDDCCBBAA, 2'd3, MODE_FIXED, 1'b1, 1'b0);

        // round robin from reset with all channels valid
        apply(4'h0, 32'h0, 2'd0, MODE_FIXED, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) apply(4'hF, 32'h44332211, 2'd0, MODE_RR, 1'b1, 1'b0);

        // only ch1/ch3 valid, pointer moved to 1, stall in between
        apply(4'b0010, 32'h44332211, 2'd0, MODE_RR, 1'b1, 1'b0);
        apply(4'b1010, 32'h44332211, 2'd0, MODE_RR, 1'b1, 1'b0);
        apply(4'b1010, 32'h44332211, 2'd0, MODE_RR, 1'b0, 1'b0);
        apply(4'b1010, 32'h44332211, 2'd0, MODE_RR, 1'b1, 1'b0);
        apply(4'b0000, 32'h0,        2'd0, MODE_RR, 1'b1, 1'b0);

        // reset while FULL and stalled, next RR grant returns to ch0
        apply(4'hF, 32'h88776655, 2'd1, MODE_FIXED, 1'b1, 1'b0);
        apply(4'hF, 32'h88776655, 2'd1, MODE_FIXED, 1'b0, 1'b1);
        apply(4'hF, 32'h88776655, 2'd1, MODE_RR,    1'b1, 1'b0);
        apply(4'h0, 32'h0,        2'd1, MODE_RR,    1'b1, 1'b0);

        for (int i = 0; i < 3000; i++) begin
            apply(4'($urandom), $urandom, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 3) != 0), ($urandom_range(0, 99) == 0));
        end
        for (int i = 0; i < 4; i++) apply(4'h0, 32'h0, 2'd0, MODE_FIXED, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
